// File: rtl/uart_recv.sv
// UART receiver: 2-flop synchronized input, mid-bit sampling, LSB-first data, single stop bit.
// Optional even-parity bit compiled in with `define UART_RECV_PARITY_EN.
module uart_recv #(
   parameter int PACKET_SIZE = 4,
   parameter int CYCLE_DIV   = 100
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   bsIn,
   output logic [PACKET_SIZE-1:0] data,
   output logic                   dataValid,
   output logic                   frameErr,
   output logic                   parityErr,
   output logic                   busy
);

   localparam int CW = $clog2(CYCLE_DIV);
   localparam int BW = $clog2(PACKET_SIZE + 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CYCLE_DIV / 2 - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CYCLE_DIV - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(PACKET_SIZE - 1);

`ifdef UART_RECV_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif

   state_t                 state, state_next;
   logic [1:0]             sync;
   logic                   line;
   logic [CW-1:0]          cnt, cnt_next;
   logic [BW-1:0]          bit_cnt, bit_next;
   logic [PACKET_SIZE-1:0] shreg, sh_next, shifted;
   logic [PACKET_SIZE-1:0] data_next;
   logic                   valid_next, ferr_next;

   // Flops reset to 1 so a reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (reset) sync <= 2'b11;
      else       sync <= {sync[0], bsIn};
   end

   assign line = sync[1];
   assign busy = (state != IDLE);

   always_comb begin
      shifted = shreg;
      for (int i = 0; i < PACKET_SIZE - 1; i++) shifted[i] = shreg[i+1];
      shifted[PACKET_SIZE-1] = line;
   end

`ifdef UART_RECV_PARITY_EN
   logic perr, perr_next, perr_pulse_next;
`endif

   always_comb begin
      state_next = state;
      cnt_next   = cnt + 1'b1;
      bit_next   = bit_cnt;
      sh_next    = shreg;
      data_next  = data;
      valid_next = 1'b0;
      ferr_next  = 1'b0;
`ifdef UART_RECV_PARITY_EN
      perr_next       = perr;
      perr_pulse_next = 1'b0;
`endif
      case (state)
         IDLE: begin
            cnt_next = '0;
            if (!line) state_next = START;
         end
         START: begin
            if (cnt == HALF_LAST) begin
               cnt_next   = '0;
               bit_next   = '0;
               state_next = line ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_next = '0;
               sh_next  = shifted;
               bit_next = bit_cnt + 1'b1;
               if (bit_cnt == LAST_BIT) begin
`ifdef UART_RECV_PARITY_EN
                  state_next = PARITY;
`else
                  state_next = STOP;
`endif
               end
            end
         end
`ifdef UART_RECV_PARITY_EN
         PARITY: begin
            if (cnt == BIT_LAST) begin
               cnt_next   = '0;
               perr_next  = (^shreg) ^ line;
               state_next = STOP;
            end
         end
`endif
         STOP: begin
            if (cnt == BIT_LAST) begin
               cnt_next = '0;
               if (line) begin
                  data_next  = shreg;
                  valid_next = 1'b1;
`ifdef UART_RECV_PARITY_EN
                  perr_pulse_next = perr;
`endif
                  state_next = IDLE;
               end else begin
                  ferr_next  = 1'b1;
                  state_next = WAIT_IDLE;
               end
            end
         end
         WAIT_IDLE: begin
            cnt_next = '0;
            if (line) state_next = IDLE;
         end
         default: begin
            cnt_next   = '0;
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         data      <= '0;
         dataValid <= 1'b0;
         frameErr  <= 1'b0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         bit_cnt   <= bit_next;
         shreg     <= sh_next;
         data      <= data_next;
         dataValid <= valid_next;
         frameErr  <= ferr_next;
      end
   end

`ifdef UART_RECV_PARITY_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perr      <= 1'b0;
         parityErr <= 1'b0;
      end else begin
         perr      <= perr_next;
         parityErr <= perr_pulse_next;
      end
   end
`else
   assign parityErr = 1'b0;
`endif

endmodule

// File: tb/tb_uart_recv.sv
// Directed bench for uart_recv (PACKET_SIZE=4, CYCLE_DIV=100); parity cases build with UART_RECV_PARITY_EN.
module tb_uart_recv;

   localparam int BIT = 100;
`ifdef UART_RECV_PARITY_EN
   localparam int NB = 7;
`else
   localparam int NB = 6;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       bsIn = 1'b1;
   logic [3:0] data;
   logic       dataValid, frameErr, parityErr, busy;

   uart_recv #(.PACKET_SIZE(4), .CYCLE_DIV(BIT)) dut (
      .clk(clk), .reset(reset), .bsIn(bsIn), .data(data),
      .dataValid(dataValid), .frameErr(frameErr), .parityErr(parityErr), .busy(busy)
   );

   always #5 clk = ~clk;

   int         cyc = 0;
   int         n_cmp = 0;
   int         n_fail = 0;
   int         fe_cnt = 0;
   int         pe_cnt = 0;
   int         both_cnt = 0;
   int         stray_cnt = 0;
   int         dv_cyc_q[$];
   logic [3:0] dv_data_q[$];
   logic [3:0] prev_data = '0;
   logic       rst_q = 1'b1;
   int         start_cyc = 0;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= reset;
   end

   // Output monitor: records pulses and any data change not accompanied by dataValid.
   always @(negedge clk) begin
      if (!rst_q) begin
         if (dataValid) begin
            dv_cyc_q.push_back(cyc);
            dv_data_q.push_back(data);
         end
         if (frameErr) fe_cnt++;
         if (parityErr) pe_cnt++;
         if (dataValid && frameErr) both_cnt++;
         if (data !== prev_data && !dataValid) stray_cnt++;
      end
      prev_data = data;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Line bits sent oldest first from bit 0; caller must be at a negedge.
   task automatic send_line(input logic [NB-1:0] bits);
      for (int i = 0; i < NB; i++) begin
         bsIn = bits[i];
         if (i == 0) start_cyc = cyc + 1;
         repeat (BIT) @(negedge clk);
      end
   endtask

   function automatic logic [NB-1:0] mk_frame(input logic [3:0] d, input logic stop_bit);
`ifdef UART_RECV_PARITY_EN
      return {stop_bit, ^d, d, 1'b0};
`else
      return {stop_bit, d, 1'b0};
`endif
   endfunction

   int dv0, fe0, elapsed;

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_data", data, 0);
      chk("rst_valid", dataValid, 0);
      chk("rst_ferr", frameErr, 0);
      chk("rst_perr", parityErr, 0);
      chk("rst_busy", busy, 0);
      reset = 1'b0;
      repeat (10) @(negedge clk);

      // Single good frame 4'hD.
      send_line(mk_frame(4'hD, 1'b1));
      repeat (20) @(negedge clk);
      chk("d_count", dv_cyc_q.size(), 1);
      if (dv_cyc_q.size() >= 1) begin
         chk("d_data", dv_data_q[0], 4'hD);
         chk("d_latency", dv_cyc_q[0] - start_cyc, 552);
      end
      chk("d_ferr", fe_cnt, 0);
      chk("d_busy", busy, 0);
      chk("d_out", data, 4'hD);

      // 20-cycle glitch.
      dv0 = dv_cyc_q.size();
      fe0 = fe_cnt;
      bsIn = 1'b0;
      start_cyc = cyc + 1;
      repeat (20) @(negedge clk);
      bsIn = 1'b1;
      chk("g_busy_hi", busy, 1);
      for (int i = 0; i < 60 && busy; i++) @(negedge clk);
      elapsed = cyc - start_cyc;
      chk("g_busy_lo", busy, 0);
      chk("g_elapsed", elapsed, 52);
      repeat (20) @(negedge clk);
      chk("g_nodv", dv_cyc_q.size(), dv0);
      chk("g_noferr", fe_cnt, fe0);
      chk("g_data", data, 4'hD);

      // Bad stop bit on 4'h6, line held low afterwards.
      send_line(mk_frame(4'h6, 1'b0));
      repeat (100) @(negedge clk);
      chk("f_ferr", fe_cnt, fe0 + 1);
      chk("f_nodv", dv_cyc_q.size(), dv0);
      chk("f_data", data, 4'hD);
      chk("f_wait_busy", busy, 1);
      bsIn = 1'b1;
      repeat (3) @(negedge clk);
      chk("f_idle", busy, 0);
      repeat (50) @(negedge clk);

      // Back-to-back 4'h3, 4'hC.
      dv0 = dv_cyc_q.size();
      send_line(mk_frame(4'h3, 1'b1));
      send_line(mk_frame(4'hC, 1'b1));
      repeat (20) @(negedge clk);
      chk("b_count", dv_cyc_q.size(), dv0 + 2);
      if (dv_cyc_q.size() >= dv0 + 2) begin
         chk("b_data0", dv_data_q[dv0], 4'h3);
         chk("b_data1", dv_data_q[dv0+1], 4'hC);
         chk("b_gap", dv_cyc_q[dv0+1] - dv_cyc_q[dv0], 600);
      end
      chk("b_out", data, 4'hC);

      // Reset in the middle of data bit 2.
      dv0 = dv_cyc_q.size();
      fe0 = fe_cnt;
      bsIn = 1'b0; repeat (BIT) @(negedge clk);
      bsIn = 1'b1; repeat (BIT) @(negedge clk);
      bsIn = 1'b0; repeat (BIT) @(negedge clk);
      bsIn = 1'b1; repeat (BIT / 2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("r_data", data, 0);
      chk("r_valid", dataValid, 0);
      chk("r_ferr", frameErr, 0);
      chk("r_busy", busy, 0);
      reset = 1'b0;
      repeat (700) @(negedge clk);
      chk("r_nodv", dv_cyc_q.size(), dv0);
      chk("r_noferr", fe_cnt, fe0);
      send_line(mk_frame(4'hA, 1'b1));
      repeat (20) @(negedge clk);
      chk("r_count", dv_cyc_q.size(), dv0 + 1);
      chk("r_out", data, 4'hA);

`ifdef UART_RECV_PARITY_EN
      // 4'h7 has three ones: parity bit 1 is good, 0 is bad.
      dv0 = dv_cyc_q.size();
      send_line({1'b1, 1'b1, 4'h7, 1'b0});
      repeat (20) @(negedge clk);
      chk("p_good_dv", dv_cyc_q.size(), dv0 + 1);
      chk("p_good_perr", pe_cnt, 0);
      send_line({1'b1, 1'b0, 4'h7, 1'b0});
      repeat (20) @(negedge clk);
      chk("p_bad_dv", dv_cyc_q.size(), dv0 + 2);
      chk("p_bad_perr", pe_cnt, 1);
      chk("p_data", data, 4'h7);
`else
      chk("np_perr", pe_cnt, 0);
`endif

      chk("never_both", both_cnt, 0);
      chk("data_stable", stray_cnt, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/uart_recv.md
UART_RECV -- requirements
Module: uart_recv

Interface
REQ-001 SHALL have parameter PACKET_SIZE, default 4, number of data bits per frame (range 1-32).
REQ-002 SHALL have parameter CYCLE_DIV, default 100, number of clk cycles per bit period (even, minimum 4).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port bsIn  input  1  asynchronous serial line; idle high.
REQ-006 SHALL have port data  output  PACKET_SIZE  last good received word.
REQ-007 SHALL have port dataValid  output  1  one-cycle pulse when data is updated.
REQ-008 SHALL have port frameErr  output  1  one-cycle pulse on a bad stop bit.
REQ-009 SHALL have port parityErr  output  1  one-cycle pulse on a parity mismatch; tied 0 when parity is compiled out.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-011 SHALL pass bsIn through a 2-flop synchronizer; the FSM sees only the synchronized bit (2-cycle latency).
REQ-012 SHALL frame as: start bit (0), PACKET_SIZE data bits LSB first, optional parity bit, one stop bit (1).
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE, with a bit-timing counter of width clog2(CYCLE_DIV).
REQ-014 IDLE: synchronized line low -> START, counter cleared.
REQ-015 START: at counter = CYCLE_DIV/2-1, sample; low -> DATA with counter cleared; high -> IDLE as a glitch (no flags raised).
REQ-016 DATA: sample at each counter = CYCLE_DIV-1 (mid-bit) and shift right into the shift register MSB; after PACKET_SIZE samples -> PARITY if enabled, else STOP.
REQ-017 PARITY: sample after CYCLE_DIV cycles; store even-parity mismatch flag -> STOP.
REQ-018 STOP: sample after CYCLE_DIV cycles; high -> load data from shift register, pulse dataValid, pulse parityErr if the mismatch flag is set, -> IDLE.
REQ-019 STOP sampled low -> pulse frameErr, leave data unchanged, no dataValid, -> WAIT_IDLE.
REQ-020 WAIT_IDLE: remain until the synchronized line is high, then -> IDLE (break/stuck-low tolerance).
REQ-021 Flag pulses SHALL be asserted in the cycle after the stop sample and last exactly one cycle; dataValid and frameErr are never asserted together.
REQ-022 data SHALL hold its value between frames; it changes only together with dataValid.
REQ-023 A new start bit is accepted the first IDLE cycle after STOP; back-to-back frames are received without loss.

Reset
REQ-024 reset high at a rising edge SHALL force state IDLE, counter 0, shift register 0, data 0, dataValid 0, frameErr 0, parityErr 0, busy 0, and both synchronizer flops 1.
REQ-025 reset mid-frame SHALL abandon the frame with no flag pulse; reception restarts on the next falling edge after reset deasserts.

Configuration
REQ-026 Macro UART_RECV_PARITY_EN defined: PARITY state present, one even-parity bit expected after data, parityErr driven per REQ-018.
REQ-027 Macro UART_RECV_PARITY_EN undefined: PARITY state absent, DATA -> STOP directly, parityErr constant 0; frame length is PACKET_SIZE+2 bits.

Verification (PACKET_SIZE=4, CYCLE_DIV=100, 10 ns clk, parity off unless stated)
REQ-028 Send 4'hD (line: 0,1,0,1,1,1 at 100 cycles/bit) -> data=4'hD, dataValid one cycle exactly 552 cycles after the first edge sampling bsIn low; frameErr=0.
REQ-029 Line-low glitch of 20 cycles from idle -> return to IDLE, busy drops after about 52 cycles, no flags, data unchanged.
REQ-030 Send 4'h6 with stop bit forced 0, then line high -> frameErr one pulse, data keeps previous 4'hD, WAIT_IDLE exits only after line high.
REQ-031 Back-to-back frames 4'h3 then 4'hC with no idle gap -> two dataValid pulses 600 cycles apart, data 4'h3 then 4'hC.
REQ-032 Assert reset for 1 cycle during DATA bit 2 -> all outputs 0, no flag; the next full frame 4'hA is received correctly.
REQ-033 With UART_RECV_PARITY_EN: send 4'h7 with parity bit 1, then with parity bit 0 -> first gives dataValid, parityErr=0; second gives dataValid plus a parityErr pulse.
